// File: rtl/cook_timer_ctrl.sv
// Countdown kitchen timer: MM:SS BCD setting, 1 s countdown, alarm at 00:00.
// Optional alarm auto-clear after ALARM_SEC ticks: COOK_TIMER_ALARM_TIMEOUT_EN.
module cook_timer_ctrl #(
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_clear,
  input  logic       alarm_off,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  state_t      state, state_n;
  logic [15:0] set_q, set_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_d;
  logic        running_d, alarm_d, done_d;

  // one BCD field 00..59, wraps 59 -> 00
  function automatic logic [7:0] inc59(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // one BCD field, caller guarantees v != 00
  function automatic logic [7:0] dec99(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // MM:SS minus one second, seconds borrow from minutes
  function automatic logic [15:0] dec_mmss(input logic [15:0] v);
    if (v[7:0] == 8'h00) return {dec99(v[15:8]), 8'h59};
    return {v[15:8], dec99(v[7:0])};
  endfunction

`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);
  logic [5:0] acnt_q;
  logic       alarm_to;

  assign alarm_to = clk_sec && (acnt_q == ALARM_LAST);

  // seconds spent in ALARM, zero whenever outside ALARM
  always_ff @(posedge clk) begin
    if (reset_p || state != S_ALARM) acnt_q <= '0;
    else if (clk_sec) acnt_q <= acnt_q + 6'd1;
  end
`else
  logic alarm_to;
  assign alarm_to = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= S_IDLE;
      set_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      set_q <= set_d;
      cnt_q <= cnt_d;
    end
  end

  // next state and next setting/count
  always_comb begin
    state_n = state;
    set_d   = set_q;
    cnt_d   = cnt_q;
    unique case (state)
      S_IDLE: begin
        if (btn_clear) begin
          set_d = '0;
        end else if (btn_start) begin
          if (set_q != 16'h0000) begin
            cnt_d   = set_q;
            state_n = S_RUN;
          end
        end else begin
          if (btn_sec) set_d[7:0]  = inc59(set_q[7:0]);
          if (btn_min) set_d[15:8] = inc59(set_q[15:8]);
        end
      end
      S_RUN: begin
        if (btn_clear) begin
          state_n = S_IDLE;
        end else if (btn_start) begin
          state_n = S_PAUSE;
        end else if (clk_sec) begin
          cnt_d = dec_mmss(cnt_q);
          if (cnt_q == 16'h0001) state_n = S_ALARM;
        end
      end
      S_PAUSE: begin
        if (btn_clear) state_n = S_IDLE;
        else if (btn_start) state_n = S_RUN;
      end
      S_ALARM: begin
        cnt_d = '0;
        if (btn_clear || btn_start || alarm_off) state_n = S_IDLE;
        else if (alarm_to) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // next output values, decoded from next state
  always_comb begin
    disp_d    = (state_n == S_IDLE) ? set_d : cnt_d;
    running_d = (state_n == S_RUN);
    alarm_d   = (state_n == S_ALARM);
    done_d    = (state_n == S_ALARM) && (state != S_ALARM);
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset_p) begin
      {min10, min1, sec10, sec1} <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
      done    <= 1'b0;
    end else begin
      {min10, min1, sec10, sec1} <= disp_d;
      running <= running_d;
      alarm   <= alarm_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: random and directed button/tick
// stimulus against a seconds-based reference model.
module tb_cook_timer_ctrl;

  localparam int ASEC = 10;

  localparam logic [6:0] R   = 7'b1000000;
  localparam logic [6:0] C   = 7'b0100000;
  localparam logic [6:0] ST  = 7'b0010000;
  localparam logic [6:0] SEC = 7'b0001000;
  localparam logic [6:0] MN  = 7'b0000100;
  localparam logic [6:0] OFF = 7'b0000010;
  localparam logic [6:0] TK  = 7'b0000001;

  logic clk = 1'b0;
  logic reset_p = 1'b0, clk_sec = 1'b0;
  logic btn_start = 1'b0, btn_sec = 1'b0;
  logic btn_min = 1'b0, btn_clear = 1'b0;
  logic alarm_off = 1'b0;
  logic [3:0] min10, min1, sec10, sec1;
  logic running, alarm, done;

  always #5 clk = ~clk;

  cook_timer_ctrl #(.ALARM_SEC(ASEC)) dut (
    .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec),
    .btn_start(btn_start), .btn_sec(btn_sec),
    .btn_min(btn_min), .btn_clear(btn_clear),
    .alarm_off(alarm_off),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .running(running), .alarm(alarm), .done(done)
  );

  typedef struct packed {
    logic [3:0] m10, m1, s10, s1;
    logic run, alm, dn;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: 0 idle, 1 run, 2 pause, 3 alarm; times in plain seconds
  int st = 0, sm = 0, ss = 0, cnt = 0, ac = 0;

  task automatic step(input logic [6:0] v);
    exp_t e;
    int disp, mm, sx;
    bit dn;
    @(negedge clk);
    {reset_p, btn_clear, btn_start, btn_sec,
     btn_min, alarm_off, clk_sec} = v;
    dn = 0;
    if (v[6]) begin
      st = 0; sm = 0; ss = 0; cnt = 0; ac = 0;
    end else begin
      case (st)
        0: if (v[5]) begin
             sm = 0; ss = 0;
           end else if (v[4]) begin
             if (sm * 60 + ss > 0) begin
               cnt = sm * 60 + ss; st = 1;
             end
           end else begin
             if (v[3]) ss = (ss + 1) % 60;
             if (v[2]) sm = (sm + 1) % 60;
           end
        1: if (v[5]) st = 0;
           else if (v[4]) st = 2;
           else if (v[0]) begin
             cnt = cnt - 1;
             if (cnt == 0) begin
               st = 3; ac = 0; dn = 1;
             end
           end
        2: if (v[5]) st = 0;
           else if (v[4]) st = 1;
        default:
           if (v[5] || v[4] || v[1]) st = 0;
           else if (v[0]) begin
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
             ac = ac + 1;
             if (ac == ASEC) st = 0;
`endif
           end
      endcase
    end
    disp = (st == 0) ? sm * 60 + ss : cnt;
    mm = disp / 60;
    sx = disp % 60;
    e.m10 = 4'(mm / 10);
    e.m1  = 4'(mm % 10);
    e.s10 = 4'(sx / 10);
    e.s1  = 4'(sx % 10);
    e.run = (st == 1);
    e.alm = (st == 3);
    e.dn  = dn;
    q.push_back(e);
  endtask

  // monitor: one output word per clock after each issued stimulus
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {min10, min1, sec10, sec1, running, alarm, done};
        n_chk++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL out cyc=%0d: got %0d%0d:%0d%0d r%b a%b d%b want %0d%0d:%0d%0d r%b a%b d%b",
                   cyc, got.m10, got.m1, got.s10, got.s1,
                   got.run, got.alm, got.dn,
                   e.m10, e.m1, e.s10, e.s1, e.run, e.alm, e.dn);
        end
      end
    end
  end

  initial begin
    int r;
    step(R);
    repeat (3) step(MN);
    repeat (5) step(SEC);
    step(0);
    step(C);
    repeat (3) step(SEC);
    step(ST);
    repeat (3) step(TK);
    step(0);
    step(OFF);
    step(0);
    step(C);
    step(MN);
    step(ST);
    step(TK);
    step(ST);
    repeat (5) step(TK);
    step(ST);
    step(TK);
    step(C);
    step(C);
    repeat (60) step(SEC);
    step(ST);
    step(0);
    repeat (10) step(SEC);
    step(ST);
    step(TK);
    step(C | TK);
    step(0);
    step(ST);
    step(TK);
    step(R);
    step(0);
    step(SEC);
    step(ST);
    step(TK);
    repeat (20) step(TK);
    step(OFF);
    step(MN);
    step(ST);
    repeat (61) step(TK);
    repeat (12) step(TK);
    step(C);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) step(TK);
      else if (r < 48) step(ST);
      else if (r < 60) step(SEC);
      else if (r < 68) step(MN);
      else if (r < 71) step(C);
      else if (r < 75) step(OFF);
      else if (r < 76) step(R);
      else step(0);
    end
    step(0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
